// File: rtl/jump_pkg.sv
// rtl/jump_pkg.sv - shared game-mode encodings, keycodes and sizing for the jump controller
package jump_pkg;

  typedef enum logic [2:0] {
    START  = 3'b000,
    PLAY   = 3'b001,
    PAUSE  = 3'b010,
    SCROLL = 3'b011,
    LOAD   = 3'b100
  } game_state_t;

  localparam logic [7:0] KEY_START = 8'h28;
  localparam logic [7:0] KEY_PAUSE = 8'h13;
  localparam logic [7:0] KEY_QUIT  = 8'h29;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_FIRE  = 8'h1E;

  localparam int SCROLL_CYCLES = 4;
  localparam int CNT_W         = 7;

endpackage

// File: rtl/up_counter.sv
// rtl/up_counter.sv - enable-gated wrapping up-counter with synchronous clear
module up_counter #(
  parameter int CNT_W = 7
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] out
);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      out <= '0;
    end else if (clear) begin
      out <= '0;
    end else if (enable) begin
      out <= out + CNT_W'(1);
    end
  end

endmodule

// File: rtl/jump_state_ctrl.sv
// rtl/jump_state_ctrl.sv - Moore game-mode FSM: keyboard start/pause/quit plus timed scroll dwell
module jump_state_ctrl
  import jump_pkg::*;
#(
  parameter int SCROLL_CYCLES_P = SCROLL_CYCLES,
  parameter int CNT_W_P         = CNT_W
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] Keycode,
  input  logic       refresh_en,
  output logic [2:0] outstate,
  output logic       loadplat
);

  localparam logic [CNT_W_P-1:0] DWELL_LAST = CNT_W_P'(SCROLL_CYCLES_P - 1);

  game_state_t        r_state;
  game_state_t        w_next;
  logic [CNT_W_P-1:0] w_dwell;
  logic               w_clear;
  logic               w_enable;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= START;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (Keycode == KEY_QUIT && r_state != START) begin
      w_next = START;
    end else begin
      case (r_state)
        START:  if (Keycode == KEY_START) w_next = LOAD;
        LOAD:   w_next = PLAY;
        PLAY: begin
          // Pause deliberately outranks a simultaneous scroll request.
          if (Keycode == KEY_PAUSE)  w_next = PAUSE;
          else if (refresh_en)       w_next = SCROLL;
        end
        PAUSE:  if (Keycode == KEY_START) w_next = PLAY;
        SCROLL: if (w_dwell == DWELL_LAST) w_next = PLAY;
        default: w_next = START;
      endcase
    end
  end

  // Clearing on entry makes the dwell count 0..SCROLL_CYCLES-1 while in SCROLL.
  assign w_clear  = (w_next == SCROLL) && (r_state != SCROLL);
  assign w_enable = (r_state == SCROLL);

  up_counter #(
    .CNT_W(CNT_W_P)
  ) u_dwell (
    .Clock (Clock),
    .Reset (Reset),
    .clear (w_clear),
    .enable(w_enable),
    .out   (w_dwell)
  );

  assign outstate = r_state;
  assign loadplat = (r_state == LOAD);

endmodule

// File: tb/tb_jump_state_ctrl.sv
// tb/tb_jump_state_ctrl.sv - scoreboard bench for jump_state_ctrl and a stand-alone up_counter
module tb_jump_state_ctrl;
  import jump_pkg::*;

  logic       Clock;
  logic       Reset;
  logic [7:0] Keycode;
  logic       refresh_en;
  logic [2:0] outstate;
  logic       loadplat;

  logic       c_clear;
  logic       c_enable;
  logic [6:0] c_out;

  typedef struct {
    logic [2:0] st;
    logic       lp;
  } exp_t;

  exp_t sb[$];
  int   n_checks;
  int   n_fail;

  jump_state_ctrl dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Keycode   (Keycode),
    .refresh_en(refresh_en),
    .outstate  (outstate),
    .loadplat  (loadplat)
  );

  up_counter #(.CNT_W(7)) u_cnt (
    .Clock (Clock),
    .Reset (Reset),
    .clear (c_clear),
    .enable(c_enable),
    .out   (c_out)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one clock of stimulus, record the expected post-edge state, then pop and compare.
  task automatic step(input logic [7:0] key, input logic ref_en, input logic [2:0] exp_st, input string tag);
    exp_t e;
    exp_t p;
    Keycode    = key;
    refresh_en = ref_en;
    e.st = exp_st;
    e.lp = (exp_st == 3'b100);
    sb.push_back(e);
    @(posedge Clock);
    #1;
    if (sb.size() == 0) begin
      check_val({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      p = sb.pop_front();
      check_val({tag, "_state"}, {29'd0, outstate}, {29'd0, p.st});
      check_val({tag, "_loadplat"}, {31'd0, loadplat}, {31'd0, p.lp});
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    Reset      = 1'b1;
    Keycode    = 8'h00;
    refresh_en = 1'b0;
    c_clear    = 1'b0;
    c_enable   = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    check_val("rst_state", {29'd0, outstate}, 32'd0);
    check_val("rst_loadplat", {31'd0, loadplat}, 32'd0);
    check_val("rst_cnt", {25'd0, c_out}, 32'd0);
    Reset = 1'b0;

    for (int i = 0; i < 10; i++) step(8'h00, 1'b0, 3'b000, "idle");

    step(KEY_START, 1'b0, 3'b100, "start_load");
    step(8'h00, 1'b0, 3'b001, "load_play");

    step(8'h00, 1'b1, 3'b011, "scr_pulse0");
    for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 3'b011, "scr_pulse");
    step(8'h00, 1'b0, 3'b001, "scr_exit");
    step(8'h00, 1'b0, 3'b001, "play_hold");

    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) step(8'h00, 1'b1, 3'b011, "scr_held");
      step(8'h00, 1'b1, 3'b001, "scr_held_gap");
    end
    step(8'h00, 1'b0, 3'b001, "scr_held_stop");

    step(KEY_PAUSE, 1'b1, 3'b010, "pause_wins");
    step(KEY_RIGHT, 1'b1, 3'b010, "pause_ignore");
    step(KEY_START, 1'b0, 3'b001, "resume");
    step(KEY_START, 1'b0, 3'b001, "start_in_play");

    step(8'h00, 1'b1, 3'b011, "scr2_enter");
    step(KEY_PAUSE, 1'b0, 3'b011, "scr2_pause_ign");
    step(8'h00, 1'b0, 3'b011, "scr2");
    step(8'h00, 1'b0, 3'b011, "scr2");
    step(8'h00, 1'b0, 3'b001, "scr2_exit");

    step(KEY_LEFT, 1'b0, 3'b001, "mv_left");
    step(KEY_RIGHT, 1'b0, 3'b001, "mv_right");
    step(KEY_FIRE, 1'b0, 3'b001, "mv_fire");
    step(8'd79, 1'b0, 3'b001, "mv_79");
    step(8'd80, 1'b0, 3'b001, "mv_80");

    step(KEY_QUIT, 1'b0, 3'b000, "quit_play");
    step(KEY_QUIT, 1'b0, 3'b000, "quit_start");
    step(KEY_START, 1'b0, 3'b100, "q_load");
    step(KEY_QUIT, 1'b0, 3'b000, "quit_load");
    step(KEY_START, 1'b0, 3'b100, "q2_load");
    step(8'h00, 1'b0, 3'b001, "q2_play");
    step(KEY_PAUSE, 1'b0, 3'b010, "q2_pause");
    step(KEY_QUIT, 1'b0, 3'b000, "quit_pause");
    step(KEY_START, 1'b0, 3'b100, "q3_load");
    step(8'h00, 1'b0, 3'b001, "q3_play");
    step(8'h00, 1'b1, 3'b011, "q3_scroll");
    step(KEY_QUIT, 1'b0, 3'b000, "quit_scroll");

    step(KEY_START, 1'b0, 3'b100, "r_load");
    step(8'h00, 1'b0, 3'b001, "r_play");
    step(8'h00, 1'b1, 3'b011, "r_scroll");
    Keycode    = 8'h00;
    refresh_en = 1'b0;
    #2;
    Reset = 1'b1;
    #1;
    check_val("async_rst_state", {29'd0, outstate}, 32'd0);
    check_val("async_rst_loadplat", {31'd0, loadplat}, 32'd0);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    step(8'h00, 1'b0, 3'b000, "post_rst");
    step(KEY_START, 1'b0, 3'b100, "pr_load");
    step(8'h00, 1'b0, 3'b001, "pr_play");
    step(8'h00, 1'b1, 3'b011, "pr_scroll");
    for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 3'b011, "pr_scroll");
    step(8'h00, 1'b0, 3'b001, "pr_exit");

    c_clear  = 1'b1;
    c_enable = 1'b0;
    @(posedge Clock);
    #1;
    check_val("cnt_clear", {25'd0, c_out}, 32'd0);
    c_clear  = 1'b0;
    c_enable = 1'b1;
    for (int k = 1; k <= 130; k++) begin
      @(posedge Clock);
      #1;
      check_val("cnt_run", {25'd0, c_out}, 32'(k % 128));
    end
    c_enable = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    check_val("cnt_hold", {25'd0, c_out}, 32'd2);
    c_clear  = 1'b1;
    c_enable = 1'b1;
    @(posedge Clock);
    #1;
    check_val("cnt_clr_pri", {25'd0, c_out}, 32'd0);
    c_clear  = 1'b0;
    c_enable = 1'b0;

    check_val("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
